// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port integer register file for the ID stage
//
// NREGS = 2**AW registers, r0 hard-wired to zero. After reset an init sweep
// zeroes r1..r(NREGS-1), one per cycle; ready rises when the sweep finishes.
// A per-register busy scoreboard tracks registers with an in-flight producer.
//
// Parameters
//   DW   data width
//   AW   address width
//   NRD  number of combinational read ports (>=1)
//
// Ports
//   clk                    rising-edge clock
//   rst                    synchronous reset, active-low
//   we0/waddr0/wdata0      write port 0 (WB pipe)
//   we1/waddr1/wdata1      write port 1 (LSU pipe), wins over port 0
//   bset_en/bset_addr      mark a register busy
//   re[NRD]                read enables
//   raddr[NRD*AW]          read addresses, port i = raddr[i*AW +: AW]
//   rdata[NRD*DW]          read data,      port i = rdata[i*DW +: DW]
//   rbusy[NRD]             source register of port i is busy
//   ready                  init sweep done
//   busy_vec[NREGS]        registered scoreboard, bit 0 always 0
//
// Build option
//   REGFILE_BYPASS_EN  forward same-cycle write data to matching reads
//                      (port 1 wins) and report such reads as not busy.
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we0,
  input  logic [AW-1:0]       waddr0,
  input  logic [DW-1:0]       wdata0,
  input  logic                we1,
  input  logic [AW-1:0]       waddr1,
  input  logic [DW-1:0]       wdata1,
  input  logic                bset_en,
  input  logic [AW-1:0]       bset_addr,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*DW-1:0]   rdata,
  output logic [NRD-1:0]      rbusy,
  output logic                ready,
  output logic [(1<<AW)-1:0]  busy_vec
);

  localparam int NREGS = 1 << AW;

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr;
  logic [DW-1:0]     regs [NREGS];
  logic [NREGS-1:0]  busy_d;
  logic              wen0, wen1, last_sweep;

  assign wen0       = we0 && (waddr0 != '0);
  assign wen1       = we1 && (waddr1 != '0);
  assign last_sweep = (state_q == INIT) && (ptr == '1);

  always_comb begin
    state_d = state_q;
    if (last_sweep) state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      ptr     <= AW'(1);
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) ptr <= ptr + AW'(1);
      if (last_sweep)      ready <= 1'b1;
    end
  end

  // Storage has no reset of its own: the sweep clears it, and reads are gated
  // until ready. r0 is never written and never read from storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == INIT) begin
        regs[ptr] <= '0;
      end else begin
        if (wen0) regs[waddr0] <= wdata0;
        if (wen1) regs[waddr1] <= wdata1;
      end
    end
  end

  // Clears first, then set, so a new producer issued in the same cycle as
  // the old one's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_vec;
    if (wen0)                          busy_d[waddr0]    = 1'b0;
    if (wen1)                          busy_d[waddr1]    = 1'b0;
    if (bset_en && bset_addr != '0)    busy_d[bset_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst)                busy_vec <= '0;
    else if (state_q == RUN) busy_vec <= busy_d;
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [AW-1:0] ra;
      ra = raddr[i*AW +: AW];
      if (rst && ready && re[i] && ra != '0) begin
        rdata[i*DW +: DW] = regs[ra];
        rbusy[i]          = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
        if (wen1 && waddr1 == ra) begin
          rdata[i*DW +: DW] = wdata1;
          rbusy[i]          = 1'b0;
        end else if (wen0 && waddr0 == ra) begin
          rdata[i*DW +: DW] = wdata0;
          rbusy[i]          = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NREGS = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                we0, we1, bset_en;
  logic [AW-1:0]       waddr0, waddr1, bset_addr;
  logic [DW-1:0]       wdata0, wdata1;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rbusy;
  logic                ready;
  logic [NREGS-1:0]    busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .bset_en(bset_en), .bset_addr(bset_addr),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .ready(ready), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; bset_en = 0;
    waddr0 = '0; waddr1 = '0; bset_addr = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic set_reads(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    re = en;
    raddr = {a1, a0};
  endtask

  // Counts edges after release until ready rises; bounded at 40.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    set_reads(2'b11, 5'd5, 5'd0);
    rst = 0;
    tick(); tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    rst = 1;
    tick();
    checks++; if (rdata !== '0) begin errors++; $display("FAIL init_rdata got %h exp 0", rdata); end
    wait_ready(n);
    n++;
    checks++; if (n !== 31 || ready !== 1'b1) begin errors++; $display("FAIL init_len got %0d ready %b exp 31 ready 1", n, ready); end
    for (int a = 0; a < NREGS; a++) begin
      set_reads(2'b11, AW'(a), AW'(NREGS-1-a));
      #1;
      checks++; if (rdata !== '0 || rbusy !== '0) begin errors++; $display("FAIL sweep_read a=%0d got %h/%b exp 0/0", a, rdata, rbusy); end
    end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL init_busy got %h exp 0", busy_vec); end
  endtask

  task automatic test_write_read();
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    tick();
    idle();
    set_reads(2'b11, 5'd5, 5'd5);
    #1;
    checks++; if (rdata[0 +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_p0 got %h exp deadbeef", rdata[0 +: DW]); end
    checks++; if (rdata[DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_p1 got %h exp deadbeef", rdata[DW +: DW]); end
    set_reads(2'b10, 5'd5, 5'd5);
    #1;
    checks++; if (rdata[0 +: DW] !== '0) begin errors++; $display("FAIL re_off got %h exp 0", rdata[0 +: DW]); end
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'h1234;
    tick();
    idle();
    set_reads(2'b11, 5'd0, 5'd0);
    #1;
    checks++; if (rdata !== '0) begin errors++; $display("FAIL r0_read got %h exp 0", rdata); end
  endtask

  task automatic test_collision();
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    idle();
    set_reads(2'b11, 5'd7, 5'd5);
    #1;
    checks++; if (rdata[0 +: DW] !== 32'h22) begin errors++; $display("FAIL collide got %h exp 22", rdata[0 +: DW]); end
    checks++; if (rdata[DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL collide_other got %h exp deadbeef", rdata[DW +: DW]); end
  endtask

  task automatic test_scoreboard();
    bset_en = 1; bset_addr = 5'd9;
    tick();
    idle();
    set_reads(2'b01, 5'd9, 5'd0);
    #1;
    checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", busy_vec[9]); end
    checks++; if (rbusy !== 2'b01) begin errors++; $display("FAIL sb_rbusy got %b exp 01", rbusy); end
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h99;
    bset_en = 1; bset_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL sb_setwins got %h exp 00000200", busy_vec); end
    checks++; if (rdata[0 +: DW] !== 32'h99) begin errors++; $display("FAIL sb_data got %h exp 99", rdata[0 +: DW]); end
    we1 = 1; waddr1 = 5'd9; wdata1 = 32'h9A;
    bset_en = 1; bset_addr = 5'd0;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL sb_clear got %h exp 0", busy_vec); end
    checks++; if (rbusy !== 2'b00 || rdata[0 +: DW] !== 32'h9A) begin errors++; $display("FAIL sb_read got %b/%h exp 00/9a", rbusy, rdata[0 +: DW]); end
  endtask

  task automatic test_bypass();
    bset_en = 1; bset_addr = 5'd3;
    tick();
    idle();
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'hA5A5A5A5;
    set_reads(2'b01, 5'd3, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (rdata[0 +: DW] !== 32'hA5A5A5A5 || rbusy[0] !== 1'b0) begin errors++; $display("FAIL byp_fwd got %h/%b exp a5a5a5a5/0", rdata[0 +: DW], rbusy[0]); end
`else
    checks++; if (rdata[0 +: DW] !== 32'h0 || rbusy[0] !== 1'b1) begin errors++; $display("FAIL byp_none got %h/%b exp 0/1", rdata[0 +: DW], rbusy[0]); end
`endif
    tick();
    idle();
    #1;
    checks++; if (rdata[0 +: DW] !== 32'hA5A5A5A5 || busy_vec[3] !== 1'b0) begin errors++; $display("FAIL byp_after got %h/%b exp a5a5a5a5/0", rdata[0 +: DW], busy_vec[3]); end
    we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1;
    we1 = 1; waddr1 = 5'd3; wdata1 = 32'h2;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (rdata[0 +: DW] !== 32'h2) begin errors++; $display("FAIL byp_p1wins got %h exp 2", rdata[0 +: DW]); end
`else
    checks++; if (rdata[0 +: DW] !== 32'hA5A5A5A5) begin errors++; $display("FAIL byp_old got %h exp a5a5a5a5", rdata[0 +: DW]); end
`endif
    tick();
    idle();
  endtask

  task automatic test_midop_reset();
    int n;
    we0 = 1; waddr0 = 5'd4; wdata0 = 32'hFF;
    bset_en = 1; bset_addr = 5'd12;
    tick();
    idle();
    set_reads(2'b01, 5'd4, 5'd0);
    #1;
    checks++; if (rdata[0 +: DW] !== 32'hFF || busy_vec[12] !== 1'b1) begin errors++; $display("FAIL mid_pre got %h/%b exp ff/1", rdata[0 +: DW], busy_vec[12]); end
    rst = 0;
    #1;
    checks++; if (rdata !== '0) begin errors++; $display("FAIL mid_gate got %h exp 0", rdata); end
    tick();
    checks++; if (ready !== 1'b0 || busy_vec !== '0) begin errors++; $display("FAIL mid_rst got %b/%h exp 0/0", ready, busy_vec); end
    rst = 1;
    // Writes and busy sets during the sweep must be ignored.
    we0 = 1; waddr0 = 5'd2; wdata0 = 32'h77;
    bset_en = 1; bset_addr = 5'd2;
    wait_ready(n);
    idle();
    checks++; if (n !== 31) begin errors++; $display("FAIL mid_len got %0d exp 31", n); end
    set_reads(2'b11, 5'd4, 5'd2);
    #1;
    checks++; if (rdata !== '0) begin errors++; $display("FAIL mid_cleared got %h exp 0", rdata); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL mid_busy got %h exp 0", busy_vec); end
  endtask

  initial begin
    rst = 0;
    idle();
    set_reads(2'b00, '0, '0);
    test_reset();
    test_write_read();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
